// File: rtl/b2_demux_1_3_tdm.sv
// Receive-side TDM demux: splits a sync-aligned A/B/C beat stream onto registered a/b/c outputs.
// Optional DEMUX_ERR_CNT_EN adds a saturating 8-bit framing-error counter output err_cnt.
module b2_demux_1_3_tdm #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             sync_err
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EXP_B = 2'b01,
    EXP_C = 2'b10,
    EXP_A = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             err_evt;

  // Framing error: sync landing on slot B/C, or a missing sync where slot A is due.
  always_comb begin
    err_evt = 1'b0;
    if (din_valid) begin
      unique case (state)
        EXP_B, EXP_C: err_evt = sync;
        EXP_A:        err_evt = !sync;
        default:      err_evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= 2'b00;
      sh_a        <= '0;
      sh_b        <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= err_evt;
      if (din_valid) begin
        unique case (state)
          IDLE, EXP_A: begin
            if (sync) begin
              sh_a  <= din;
              state <= EXP_B;
              slot  <= 2'b01;
            end else begin
              state <= IDLE;
              slot  <= 2'b00;
            end
          end
          EXP_B: begin
            if (sync) begin
              sh_a <= din;
            end else begin
              sh_b  <= din;
              state <= EXP_C;
              slot  <= 2'b10;
            end
          end
          EXP_C: begin
            if (sync) begin
              sh_a  <= din;
              state <= EXP_B;
              slot  <= 2'b01;
            end else begin
              a           <= sh_a;
              b           <= sh_b;
              c           <= din;
              frame_valid <= 1'b1;
              state       <= EXP_A;
              slot        <= 2'b00;
            end
          end
          default: begin
            state <= IDLE;
            slot  <= 2'b00;
          end
        endcase
      end
    end
  end

`ifdef DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_evt && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_b2_demux_1_3_tdm.sv
// Directed bench for b2_demux_1_3_tdm: expected frames are queued as beats are sent and
// popped when frame_valid is due; also covers err_cnt when DEMUX_ERR_CNT_EN is defined.
module tb_b2_demux_1_3_tdm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] din = '0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] a, b, c;
  logic       frame_valid;
  logic [1:0] slot;
  logic       sync_err;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [5:0]  sb[$];
  logic [5:0]  held = '0;

  b2_demux_1_3_tdm #(.WIDTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .a           (a),
    .b           (b),
    .c           (c),
    .frame_valid (frame_valid),
    .slot        (slot),
    .sync_err    (sync_err)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, then check the registered outputs just after the edge.
  task automatic step(input logic v, input logic s, input logic [1:0] d,
                      input logic exp_fv, input logic exp_err, input logic [1:0] exp_slot);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    #1;
    if (exp_fv && sb.size() != 0) held = sb.pop_front();
    check("frame_valid", frame_valid, exp_fv);
    check("sync_err", sync_err, exp_err);
    check("slot", slot, exp_slot);
    check("abc", {a, b, c}, held);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    sb.delete();
    held = '0;
    #1;
    check("rst_abc", {a, b, c}, 6'b0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_err", sync_err, 1'b0);
    check("rst_slot", slot, 2'b00);
`ifdef DEMUX_ERR_CNT_EN
    check("rst_err_cnt", err_cnt, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // Basic frame at full rate
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10);
    sb.push_back({2'b00, 2'b01, 2'b10});
    step(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);

    // Same frame with din_valid gaps
    do_reset();
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10);
    sb.push_back({2'b00, 2'b01, 2'b10});
    step(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);

    // Missing sync in EXP_A drops to IDLE; a following non-sync beat is silent there
    step(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);

    // Resync in EXP_C, then back-to-back frames
    do_reset();
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10);
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b01);
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10);
    sb.push_back({2'b11, 2'b01, 2'b10});
    step(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
`ifdef DEMUX_ERR_CNT_EN
    check("err_cnt_resync", err_cnt, 8'h01);
`endif
    step(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10);
    sb.push_back({2'b10, 2'b11, 2'b00});
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10);
    sb.push_back({2'b01, 2'b00, 2'b11});
    step(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'b00);

    // Reset mid-frame discards the partial frame
    do_reset();
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b10);
    do_reset();
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00);

    // Long non-sync hunt in IDLE
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'b0, 2'($urandom_range(3)), 1'b0, 1'b0, 2'b00);

    // Repeated resyncs in EXP_B drive the error counter to saturation
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01);
    for (int i = 0; i < 254; i++)
      step(1'b1, 1'b1, 2'($urandom_range(3)), 1'b0, 1'b1, 2'b01);
`ifdef DEMUX_ERR_CNT_EN
    check("err_cnt_fe", err_cnt, 8'hFE);
`endif
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 2'($urandom_range(3)), 1'b0, 1'b1, 2'b01);
`ifdef DEMUX_ERR_CNT_EN
    check("err_cnt_sat", err_cnt, 8'hFF);
`endif
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01);

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
